// File: rtl/dac_wave_gen.sv
// dac_wave_gen: sample source for the serial DAC serializer.
// Generates one 16-bit DAC frame per DIV clock cycles. The waveform is chosen
// by ctrl: sawtooth, triangle, square or DC midscale. Frames go downstream over
// a valid/ready handshake. If a sample period ends while the previous frame is
// still pending, the new sample is dropped and a sticky overrun flag is set.
// The phase keeps advancing in that case, so the output frequency is preserved.

module dac_wave_gen #(
  parameter int unsigned DIV  = 1250,  // sample period in clk cycles, 2..2048
  parameter int unsigned STEP = 16     // phase increment per sample (12-bit)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ctrl,
  output logic [15:0] frame,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        overrun
);

  localparam logic [10:0] DIV_LAST = 11'(DIV - 1);
  localparam logic [11:0] PH_STEP  = 12'(STEP);

  localparam logic [1:0] MODE_SAW = 2'b00;
  localparam logic [1:0] MODE_TRI = 2'b01;
  localparam logic [1:0] MODE_SQR = 2'b10;
  localparam logic [1:0] MODE_DC  = 2'b11;

  // Map a phase value to a 12-bit DAC code for the selected waveform.
  // The triangle doubles the low 11 phase bits: the ramp rises in the first
  // half of the phase and, because it is inverted, falls in the second half.
  function automatic logic [11:0] wave_code(input logic [1:0]  sel,
                                            input logic [11:0] p);
    logic [11:0] code;
    code = 12'h000;
    unique case (sel)
      MODE_SAW: code = p;
      MODE_TRI: code = p[11] ? ~{p[10:0], 1'b0} : {p[10:0], 1'b0};
      MODE_SQR: code = p[11] ? 12'hFFF : 12'h000;
      MODE_DC:  code = 12'h800;
      default:  code = 12'h000;
    endcase
    return code;
  endfunction

  // State registers and their next-state values.
  logic [10:0] cntdiv_q,      cntdiv_d;
  logic [11:0] phase_q,       phase_d;
  logic [1:0]  ctrl_q,        ctrl_d;
  logic [15:0] frame_q,       frame_d;
  logic        frame_valid_q, frame_valid_d;
  logic        overrun_q,     overrun_d;

  // Decoded per-cycle conditions.
  logic        tick;
  logic        slot_free;
  logic        xfer;
  logic [11:0] phase_sel;

  // Divider tick, handshake status, and the phase to use on this tick.
  // A change of waveform restarts the phase at 0, so the new waveform
  // always begins at the start of its period.
  always_comb begin
    tick      = (cntdiv_q == DIV_LAST);
    slot_free = !frame_valid_q || frame_ready;
    xfer      = frame_valid_q && frame_ready;
    phase_sel = (ctrl != ctrl_q) ? 12'h000 : phase_q;
  end

  // Next state: the divider, the phase accumulator and the frame handshake.
  always_comb begin
    cntdiv_d      = tick ? 11'd0 : cntdiv_q + 11'd1;
    phase_d       = phase_q;
    ctrl_d        = ctrl_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;

    if (tick) begin
      // The phase advances on every tick, even when the sample is dropped.
      phase_d = phase_sel + PH_STEP;
      ctrl_d  = ctrl;
      if (slot_free) begin
        // The slot is empty or is being emptied on this edge. Load the new
        // frame back-to-back so that frame_valid stays high.
        frame_d       = {4'b0000, wave_code(ctrl, phase_sel)};
        frame_valid_d = 1'b1;
      end else begin
        // The previous frame is still pending. Hold it and flag the drop.
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      frame_valid_d = 1'b0;
    end
  end

  // Register update. Reset overrides everything and discards any pending frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cntdiv_q      <= 11'd0;
      phase_q       <= 12'h000;
      ctrl_q        <= 2'b00;
      frame_q       <= 16'h0000;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      cntdiv_q      <= cntdiv_d;
      phase_q       <= phase_d;
      ctrl_q        <= ctrl_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// tb_dac_wave_gen: directed bench for dac_wave_gen.
// Instance a has DIV=4 and STEP=16. It covers sawtooth, mode change,
// backpressure, simultaneous tick and transfer, and reset.
// Instance b has DIV=4 and STEP=512. It covers the triangle and square tables.

module tb_dac_wave_gen;

  logic        clk = 1'b0;

  logic        rst_a   = 1'b1;
  logic [1:0]  ctrl_a  = 2'b00;
  logic        ready_a = 1'b1;
  logic [15:0] frame_a;
  logic        valid_a;
  logic        ovr_a;

  logic        rst_b   = 1'b1;
  logic [1:0]  ctrl_b  = 2'b01;
  logic        ready_b = 1'b1;
  logic [15:0] frame_b;
  logic        valid_b;
  logic        ovr_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] tri_tab [8] = '{12'h000, 12'h400, 12'h800, 12'hC00,
                               12'hFFF, 12'hBFF, 12'h7FF, 12'h3FF};

  always #5 clk = ~clk;

  dac_wave_gen #(.DIV(4), .STEP(16)) dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .ctrl       (ctrl_a),
    .frame      (frame_a),
    .frame_valid(valid_a),
    .frame_ready(ready_a),
    .overrun    (ovr_a)
  );

  dac_wave_gen #(.DIV(4), .STEP(512)) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .ctrl       (ctrl_b),
    .frame      (frame_b),
    .frame_valid(valid_b),
    .frame_ready(ready_b),
    .overrun    (ovr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state (instance a) ----------------
    step();
    check("rst_frame", 32'(frame_a), 32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_ovr",   32'(ovr_a),   32'h0);
    rst_a = 1'b0;

    // ---------------- sawtooth, first tick at edge 4 ----------------
    for (int e = 1; e <= 3; e++) begin
      step();
      check("saw_pre_tick_valid", 32'(valid_a), 32'h0);
    end
    step();
    check("saw_first_valid", 32'(valid_a), 32'h1);
    check("saw_first_frame", 32'(frame_a), 32'h0000);

    for (int s = 1; s <= 256; s++) begin
      step();
      check("saw_pulse_low", 32'(valid_a), 32'h0);
      repeat (3) step();
      check("saw_valid", 32'(valid_a), 32'h1);
      check("saw_frame", 32'(frame_a), 32'((s * 16) % 4096));
    end
    check("saw_no_ovr", 32'(ovr_a), 32'h0);

    // ---------------- mode change: DC, then back to sawtooth ----------------
    ctrl_a = 2'b11;
    repeat (4) step();
    check("dc_frame", 32'(frame_a), 32'h0800);
    ctrl_a = 2'b00;
    repeat (4) step();
    check("saw_restart_0", 32'(frame_a), 32'h0000);
    repeat (4) step();
    check("saw_restart_1", 32'(frame_a), 32'h0010);

    // ---------------- backpressure ----------------
    ready_a = 1'b0;
    rst_a   = 1'b1;
    step();
    rst_a = 1'b0;
    repeat (4) step();                         // edge 4: first frame
    check("bp_first_valid", 32'(valid_a), 32'h1);
    check("bp_first_frame", 32'(frame_a), 32'h0000);
    check("bp_no_ovr_yet",  32'(ovr_a),   32'h0);
    repeat (4) step();                         // edge 8: second tick, dropped
    check("bp_ovr_set",    32'(ovr_a),   32'h1);
    check("bp_frame_held", 32'(frame_a), 32'h0000);
    check("bp_valid_held", 32'(valid_a), 32'h1);
    repeat (6) step();                         // edge 14: ready low for 10 edges
    check("bp_frame_held2", 32'(frame_a), 32'h0000);
    check("bp_valid_held2", 32'(valid_a), 32'h1);
    ready_a = 1'b1;
    step();                                    // edge 15: transfer completes
    check("bp_xfer_done", 32'(valid_a), 32'h0);
    step();                                    // edge 16: phase is 3*STEP
    check("bp_next_valid", 32'(valid_a), 32'h1);
    check("bp_next_frame", 32'(frame_a), 32'h0030);
    check("bp_ovr_sticky", 32'(ovr_a),   32'h1);

    // ---------------- reset while pending with overrun ----------------
    ready_a = 1'b0;
    rst_a   = 1'b1;
    step();
    check("mrst_frame", 32'(frame_a), 32'h0);
    check("mrst_valid", 32'(valid_a), 32'h0);
    check("mrst_ovr",   32'(ovr_a),   32'h0);
    rst_a = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      check("mrst_pre_tick_valid", 32'(valid_a), 32'h0);
    end
    step();
    check("mrst_first_valid", 32'(valid_a), 32'h1);
    check("mrst_first_frame", 32'(frame_a), 32'h0000);

    // ---------------- simultaneous tick and transfer ----------------
    repeat (3) step();                         // edges 5..7, still pending
    ready_a = 1'b1;
    step();                                    // edge 8: tick and transfer
    check("tt_valid", 32'(valid_a), 32'h1);
    check("tt_frame", 32'(frame_a), 32'h0010);
    check("tt_no_ovr", 32'(ovr_a), 32'h0);
    step();                                    // edge 9: transfer, no tick
    check("tt_drain", 32'(valid_a), 32'h0);

    // ---------------- triangle, STEP=512 (instance b) ----------------
    rst_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      repeat (4) step();
      check("tri_valid", 32'(valid_b), 32'h1);
      check("tri_frame", 32'(frame_b), {20'h0, tri_tab[i % 8]});
    end

    // ---------------- square, STEP=512 ----------------
    ctrl_b = 2'b10;
    for (int i = 0; i < 16; i++) begin
      repeat (4) step();
      check("sqr_frame", 32'(frame_b), ((i % 8) < 4) ? 32'h0000 : 32'h0FFF);
    end
    check("b_no_ovr", 32'(ovr_b), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
